mac_filter: RTL and testbench

MAC_FILTER -- requirements
Module: mac_filter

---
 rtl/mac_filter_pkg.sv | 10 +
 rtl/mac_addr_match.sv | 22 ++
 rtl/mac_filter.sv | 95 +++++++++
 tb/tb_mac_filter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mac_filter_pkg.sv
// mac_filter_pkg: shared constants, state encoding and helpers for the MAC address filter
package mac_filter_pkg;
  localparam int MAC_W = 48;
  localparam logic [MAC_W-1:0] BROADCAST_ADDR = 48'hFFFF_FFFF_FFFF;
  localparam int MCAST_BIT = 40;
  typedef enum logic [2:0] {SYNC, IDLE, DEST, SRC, PASS, DROP} state_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return &v ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/mac_addr_match.sv
// mac_addr_match: combinational unicast table lookup, lowest matching index wins
module mac_addr_match
  import mac_filter_pkg::*;
#(
  parameter int NUM_ADDR = 4,
  parameter int IW = $clog2(NUM_ADDR) + 1
) (
  input  logic [MAC_W-1:0]          addr,
  input  logic [NUM_ADDR*MAC_W-1:0] mac_table,
  output logic                      hit,
  output logic [IW-1:0]             idx
);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_ADDR - 1; i >= 0; i--)
      if (mac_table[i*MAC_W +: MAC_W] == addr) begin
        hit = 1'b1;
        idx = IW'(i);
      end
  end
endmodule

// File: rtl/mac_filter.sv
// mac_filter: strips dest/src addresses from a beat stream and passes payload of accepted frames
module mac_filter
  import mac_filter_pkg::*;
#(
  parameter int DW = 2,
  parameter int NUM_ADDR = 4,
  parameter logic [NUM_ADDR*MAC_W-1:0] MAC_TABLE = {NUM_ADDR{48'h69_69_5A_06_54_91}},
  parameter bit ACCEPT_BCAST = 1'b1,
  parameter bit ACCEPT_MCAST = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            axiiv,
  input  logic [DW-1:0]                   axiid,
  input  logic                            promisc,
  output logic                            axiov,
  output logic [DW-1:0]                   axiod,
  output logic [$clog2(NUM_ADDR):0]       match_idx,
  output logic                            frame_ok,
  output logic [15:0]                     drop_cnt,
  output logic [15:0]                     runt_cnt
);
  localparam int BEATS = MAC_W / DW;
  localparam int CW = $clog2(BEATS);
  localparam int MW = $clog2(NUM_ADDR) + 1;
  state_t state;
  logic [CW-1:0] count;
  logic [MAC_W-1:0] dest, addr;
  logic [MW-1:0] tbl_idx, sel_idx;
  logic last, tbl_hit, bcast, mcast, accept;
  assign addr = MAC_W'({dest, axiid});
  assign last = count == CW'(BEATS - 1);
  mac_addr_match #(.NUM_ADDR(NUM_ADDR), .IW(MW)) u_match (
    .addr(addr),
    .mac_table(MAC_TABLE),
    .hit(tbl_hit),
    .idx(tbl_idx)
  );
  assign bcast = ACCEPT_BCAST && addr == BROADCAST_ADDR;
  assign mcast = ACCEPT_MCAST && addr[MCAST_BIT];
  assign accept = promisc | tbl_hit | bcast | mcast;
  assign sel_idx = promisc ? '1 : tbl_hit ? tbl_idx : bcast ? MW'(NUM_ADDR) : MW'(NUM_ADDR + 1);
  // rst gates the pass-through so an aborted frame emits nothing in the reset cycle
  assign axiov = state == PASS && axiiv && !rst;
  assign axiod = axiov ? axiid : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SYNC;
      count     <= '0;
      dest      <= '0;
      match_idx <= '1;
      frame_ok  <= 1'b0;
      drop_cnt  <= '0;
      runt_cnt  <= '0;
    end else begin
      frame_ok <= state == SRC && axiiv && last;
      case (state)
        SYNC: if (!axiiv) state <= IDLE;
        IDLE: if (axiiv) begin
          state <= DEST;
          dest  <= addr;
          count <= CW'(1);
        end
        DEST: if (!axiiv) begin
          state    <= IDLE;
          count    <= '0;
          runt_cnt <= sat_inc(runt_cnt);
        end else begin
          dest  <= addr;
          count <= last ? '0 : count + CW'(1);
          if (last) begin
            state <= accept ? SRC : DROP;
            if (accept) match_idx <= sel_idx;
            else drop_cnt <= sat_inc(drop_cnt);
          end
        end
        SRC: if (!axiiv) begin
          state    <= IDLE;
          count    <= '0;
          runt_cnt <= sat_inc(runt_cnt);
        end else begin
          count <= last ? '0 : count + CW'(1);
          if (last) state <= PASS;
        end
        // frame_ok is high only in the first PASS cycle: ending there means no payload
        PASS: if (!axiiv) begin
          state <= IDLE;
          if (frame_ok) runt_cnt <= sat_inc(runt_cnt);
        end
        DROP: if (!axiiv) state <= IDLE;
        default: state <= SYNC;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_filter.sv
// tb_mac_filter: scoreboard bench over DW=2, DW=8 (mcast) and DW=4 (no bcast) builds
module tb_mac_filter;
  logic clk = 1'b0, rst = 1'b1, promisc = 1'b0;
  logic v_a = 1'b0, v_b = 1'b0, v_c = 1'b0;
  logic [1:0] d_a = '0;
  logic [7:0] d_b = '0;
  logic [3:0] d_c = '0;
  logic ov_a, ov_b, ov_c, fok_a, fok_b, fok_c;
  logic [1:0] od_a;
  logic [7:0] od_b;
  logic [3:0] od_c;
  logic [2:0] idx_a, idx_b, idx_c;
  logic [15:0] drop_a, drop_b, drop_c, runt_a, runt_b, runt_c;
  logic [7:0] exp_q [3][$];
  int fok_cnt [3];
  int vectors = 0, miscompares = 0;
  localparam logic [47:0] GOOD = 48'h69695A065491, BC = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] MC = 48'h01005E000001, UNK = 48'h123456789ABC, SRCA = 48'hA1B2C3D4E5F6;
  localparam logic [79:0] PAY = 80'hA5_3C_0F_96_E1_7B_22_D4_5A_C3;

  always #5 clk = ~clk;

  mac_filter #(.DW(2), .MAC_TABLE({48'h020000000003, 48'h020000000002, 48'h020000000001, GOOD})) u_a (
    .clk(clk), .rst(rst), .axiiv(v_a), .axiid(d_a), .promisc(promisc), .axiov(ov_a), .axiod(od_a),
    .match_idx(idx_a), .frame_ok(fok_a), .drop_cnt(drop_a), .runt_cnt(runt_a));
  mac_filter #(.DW(8), .ACCEPT_MCAST(1'b1)) u_b (
    .clk(clk), .rst(rst), .axiiv(v_b), .axiid(d_b), .promisc(promisc), .axiov(ov_b), .axiod(od_b),
    .match_idx(idx_b), .frame_ok(fok_b), .drop_cnt(drop_b), .runt_cnt(runt_b));
  mac_filter #(.DW(4), .ACCEPT_BCAST(1'b0)) u_c (
    .clk(clk), .rst(rst), .axiiv(v_c), .axiid(d_c), .promisc(promisc), .axiov(ov_c), .axiod(od_c),
    .match_idx(idx_c), .frame_ok(fok_c), .drop_cnt(drop_c), .runt_cnt(runt_c));

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic mon(input int k, input logic valid, input logic [7:0] val, input logic fok);
    logic [7:0] e;
    fok_cnt[k] += int'(fok);
    if (valid) begin
      vectors++;
      if (exp_q[k].size() == 0) begin
        miscompares++;
        $display("FAIL out%0d: unexpected beat %h, no beat expected", k, val);
      end else begin
        e = exp_q[k].pop_front();
        if (val !== e) begin
          miscompares++;
          $display("FAIL out%0d: beat %h, expected %h", k, val, e);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, ov_a, {6'b0, od_a}, fok_a);
    mon(1, ov_b, od_b, fok_b);
    mon(2, ov_c, {4'b0, od_c}, fok_c);
  end

  task automatic drive(input int k, input logic v, input logic [7:0] b);
    case (k)
      0: begin v_a = v; d_a = b[1:0]; end
      1: begin v_b = v; d_b = b; end
      default: begin v_c = v; d_c = b[3:0]; end
    endcase
  endtask

  task automatic send(input int k, input logic [47:0] dst, input int npay, input int cut,
                      input int rst_at, input int pr_from, input bit pass);
    logic [175:0] s, t;
    logic [7:0] b;
    int w, hb, n, m;
    w = k == 0 ? 2 : k == 1 ? 8 : 4;
    m = (1 << w) - 1;
    hb = 96 / w;
    n = cut >= 0 ? cut : hb + npay;
    s = {dst, SRCA, PAY};
    fok_cnt[k] = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst = rst_at >= 0 && i == hb + rst_at;
      promisc = pr_from >= 0 && i >= pr_from;
      t = s >> (176 - (i + 1) * w);
      b = t[7:0] & 8'(m);
      drive(k, 1'b1, b);
      if (pass && i >= hb && (rst_at < 0 || i < hb + rst_at)) exp_q[k].push_back(b);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    promisc = 1'b0;
    drive(k, 1'b0, 8'h00);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("A idx reset", int'(idx_a), 7);
    chk("B idx reset", int'(idx_b), 7);
    chk("A drop reset", int'(drop_a), 0);
    chk("A runt reset", int'(runt_a), 0);
    chk("A axiov reset", int'(ov_a), 0);
    chk("A frame_ok reset", int'(fok_a), 0);
    @(posedge clk); #1;
    send(0, GOOD, 10, -1, -1, -1, 1'b1);
    chk("A good fok", fok_cnt[0], 1);
    chk("A good idx", int'(idx_a), 0);
    send(1, GOOD, 10, -1, -1, -1, 1'b1);
    chk("B good fok", fok_cnt[1], 1);
    chk("B good idx", int'(idx_b), 0);
    send(2, GOOD, 20, -1, -1, -1, 1'b1);
    chk("C good fok", fok_cnt[2], 1);
    chk("C good idx", int'(idx_c), 0);
    send(0, BC, 4, -1, -1, -1, 1'b1);
    chk("A bcast idx", int'(idx_a), 4);
    send(2, BC, 4, -1, -1, -1, 1'b0);
    chk("C bcast drop_cnt", int'(drop_c), 1);
    chk("C bcast idx kept", int'(idx_c), 0);
    chk("C bcast fok", fok_cnt[2], 0);
    send(1, MC, 3, -1, -1, -1, 1'b1);
    chk("B mcast idx", int'(idx_b), 5);
    send(0, MC, 3, -1, -1, -1, 1'b0);
    chk("A mcast drop_cnt", int'(drop_a), 1);
    chk("A mcast idx kept", int'(idx_a), 4);
    send(0, UNK, 4, -1, -1, 0, 1'b1);
    chk("A promisc idx", int'(idx_a), 7);
    send(0, UNK, 4, -1, -1, 24, 1'b0);
    chk("A late promisc drop_cnt", int'(drop_a), 2);
    send(0, 48'h020000000002, 3, -1, -1, -1, 1'b1);
    chk("A entry2 idx", int'(idx_a), 2);
    send(0, GOOD, 0, 30, -1, -1, 1'b0);
    chk("A cut30 runt_cnt", int'(runt_a), 1);
    chk("A cut30 fok", fok_cnt[0], 0);
    send(0, GOOD, 5, -1, -1, -1, 1'b1);
    chk("A after gap fok", fok_cnt[0], 1);
    chk("A after gap idx", int'(idx_a), 0);
    send(0, GOOD, 0, 48, -1, -1, 1'b0);
    chk("A end on last src runt_cnt", int'(runt_a), 2);
    send(0, GOOD, 8, -1, 5, -1, 1'b1);
    chk("A post-rst runt_cnt", int'(runt_a), 0);
    chk("A post-rst drop_cnt", int'(drop_a), 0);
    chk("C post-rst drop_cnt", int'(drop_c), 0);
    chk("A post-rst idx", int'(idx_a), 7);
    chk("B post-rst idx", int'(idx_b), 7);
    send(0, GOOD, 6, -1, -1, -1, 1'b1);
    chk("A post-rst frame fok", fok_cnt[0], 1);
    chk("A post-rst frame idx", int'(idx_a), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("A beats left", exp_q[0].size(), 0);
    chk("B beats left", exp_q[1].size(), 0);
    chk("C beats left", exp_q[2].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
